// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-port RAM between fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [15:0]       if_grants,
  output logic [15:0]       d_grants
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q;
  logic                gnt_d_q;
  logic                last_d_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                if_ack_q;
  logic                if_err_q;
  logic [31:0]         if_rdata_q;
  logic                d_ack_q;
  logic                d_err_q;
  logic [31:0]         d_rdata_q;
  logic [15:0]         if_grants_q;
  logic [15:0]         d_grants_q;

  logic                any_req;
  logic                pick_d;
  logic [31:0]         sel_addr;
  logic                sel_we;
  logic [31:0]         sel_wdata;
  logic                addr_err;
  logic                fin;
  logic                fin_d;
  logic                fin_err;
  logic [31:0]         fin_rdata;

  // On a tie the port that did not win last time gets the grant.
  assign any_req   = if_req | d_req;
  assign pick_d    = d_req & (~if_req | ~last_d_q);
  assign sel_addr  = pick_d ? d_addr : if_addr;
  assign sel_we    = pick_d & d_we;
  assign sel_wdata = pick_d ? d_wdata : 32'h0;
  assign addr_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != 32'h0);

  always_comb begin
    fin       = 1'b0;
    fin_d     = gnt_d_q;
    fin_err   = 1'b0;
    fin_rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (any_req && addr_err) begin
          fin     = 1'b1;
          fin_d   = pick_d;
          fin_err = 1'b1;
        end
      end
      ISSUE: fin = we_q;
      WAIT: begin
        if (cnt_q == '0) begin
          fin       = 1'b1;
          fin_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_d_q     <= 1'b0;
      last_d_q    <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      if_grants_q <= 16'h0;
      d_grants_q  <= 16'h0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_d_q  <= pick_d;
            last_d_q <= pick_d;
            we_q     <= sel_we;
            busy_q   <= 1'b1;
            if (addr_err) begin
              state_q <= DONE;
            end else begin
              state_q     <= ISSUE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we;
              mem_addr_q  <= sel_addr[ADDR_W+1:2];
              mem_wdata_q <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (fin) begin
        if (fin_d) begin
          d_ack_q   <= 1'b1;
          d_err_q   <= fin_err;
          d_rdata_q <= fin_rdata;
          if (d_grants_q != 16'hFFFF) d_grants_q <= d_grants_q + 16'h1;
        end else begin
          if_ack_q   <= 1'b1;
          if_err_q   <= fin_err;
          if_rdata_q <= fin_rdata;
          if (if_grants_q != 16'hFFFF) if_grants_q <= if_grants_q + 16'h1;
        end
      end
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign if_grants = if_grants_q;
  assign d_grants  = d_grants_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W = 6;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'h0;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              if_err;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [31:0]       d_addr = 32'h0;
  logic [31:0]       d_wdata = 32'h0;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic [15:0]       if_grants;
  logic [15:0]       d_grants;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .if_grants(if_grants), .d_grants(d_grants)
  );

  // RAM with an RD_LAT-deep read pipeline
  logic [31:0] ram [DEPTH];
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= ram[mem_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] shadow [DEPTH];
  bit          m_last_d = 1'b1;
  int          m_if_cnt = 0;
  int          m_d_cnt = 0;
  logic [31:0] m_if_rd = 32'h0;
  logic [31:0] m_d_rd = 32'h0;
  bit          m_if_err = 1'b0;
  bit          m_d_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'h0);
  endfunction

  function automatic int lat_of(input bit err, input bit we);
    if (err) return 1;
    if (we) return 2;
    return 2 + RD_LAT;
  endfunction

  function automatic logic [31:0] gen_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return {24'h0, 2'b00, 6'($urandom_range(0, DEPTH-1))} | 32'($urandom_range(1, 3)) << 0 | 32'h0;
    if (r == 1) return ($urandom | 32'h100) & 32'hFFFF_FFFC;
    if (r < 5)  return 32'($urandom_range(0, 7)) << 2;
    return 32'($urandom_range(0, DEPTH-1)) << 2;
  endfunction

  // One scenario: one or both ports request together; the model orders them round-robin.
  task automatic run_scn(input bit use_if, input bit use_d, input logic [31:0] ia,
                         input logic [31:0] da, input bit dwe, input logic [31:0] dwd);
    bit          port [2];
    logic [31:0] addr [2];
    bit          we [2];
    bit          err [2];
    logic [31:0] exp_rd [2];
    int          exp_t [2];
    int          n_exp;
    int          seen;
    int          t0;
    int          en_cnt;
    int          en_exp;
    logic [31:0] a;
    n_exp = 0;
    if (use_if && use_d) begin
      port[0] = ~m_last_d;
      port[1] = m_last_d;
      n_exp = 2;
    end else if (use_if || use_d) begin
      port[0] = use_d;
      n_exp = 1;
    end
    en_exp = 0;
    for (int k = 0; k < n_exp; k++) begin
      addr[k] = port[k] ? da : ia;
      we[k]   = port[k] & dwe;
      err[k]  = addr_bad(addr[k]);
      a = addr[k];
      exp_rd[k] = (err[k] || we[k]) ? 32'h0 : shadow[a[ADDR_W+1:2]];
      if (!err[k] && we[k]) shadow[a[ADDR_W+1:2]] = dwd;
      if (!err[k]) en_exp++;
      exp_t[k] = (k == 0) ? lat_of(err[k], we[k]) : exp_t[0] + 1 + lat_of(err[k], we[k]);
    end
    if (n_exp > 0) m_last_d = port[n_exp-1];

    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);
    if_req = use_if; if_addr = ia;
    d_req = use_d; d_we = dwe; d_addr = da; d_wdata = dwd;
    t0 = cyc;
    seen = 0;
    en_cnt = 0;
    for (int c = 0; c < 40 && seen < n_exp; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        a = addr[seen];
        check("mem_addr", {26'h0, mem_addr}, {26'h0, a[ADDR_W+1:2]});
        check("mem_we", {31'h0, mem_we}, {31'h0, we[seen]});
        if (we[seen]) check("mem_wdata", mem_wdata, dwd);
      end
      if (if_ack || d_ack) begin
        check("ack_port", {30'h0, if_ack, d_ack}, port[seen] ? 32'h1 : 32'h2);
        check("ack_time", 32'(cyc - t0), 32'(exp_t[seen]));
        check("busy_done", {31'h0, busy}, 32'h1);
        if (port[seen]) begin
          check("d_rdata", d_rdata, exp_rd[seen]);
          check("d_err", {31'h0, d_err}, {31'h0, err[seen]});
          m_d_rd = exp_rd[seen]; m_d_err = err[seen];
          if (m_d_cnt < 65535) m_d_cnt++;
          d_req = 1'b0;
        end else begin
          check("if_rdata", if_rdata, exp_rd[seen]);
          check("if_err", {31'h0, if_err}, {31'h0, err[seen]});
          m_if_rd = exp_rd[seen]; m_if_err = err[seen];
          if (m_if_cnt < 65535) m_if_cnt++;
          if_req = 1'b0;
        end
        seen++;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    check("acks_seen", 32'(seen), 32'(n_exp));
    check("mem_en_count", 32'(en_cnt), 32'(en_exp));
    @(negedge clk);
    check("acks_low", {30'h0, if_ack, d_ack}, 32'h0);
    check("if_hold", {if_rdata[30:0], if_err}, {m_if_rd[30:0], m_if_err});
    check("d_hold", {d_rdata[30:0], d_err}, {m_d_rd[30:0], m_d_err});
    check("if_grants", {16'h0, if_grants}, 32'(m_if_cnt));
    check("d_grants", {16'h0, d_grants}, 32'(m_d_cnt));
  endtask

  initial begin
    bit any_ack;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check("rst_acks", {28'h0, if_ack, d_ack, if_err, d_err}, 32'h0);
    check("rst_rdata", if_rdata | d_rdata, 32'h0);
    check("rst_mem", {mem_en, mem_we, 24'h0, mem_addr} | mem_wdata, 32'h0);
    check("rst_misc", {busy, 15'h0, if_grants | d_grants}, 32'h0);
    reset = 1'b1;

    run_scn(1, 1, 32'h0, 32'h4, 1'b0, 32'h0);
    run_scn(1, 1, 32'h0, 32'h4, 1'b0, 32'h0);
    run_scn(0, 1, 32'h0, 32'h10, 1'b1, 32'hDEADBEEF);
    run_scn(1, 0, 32'h10, 32'h0, 1'b1, 32'h0);
    run_scn(0, 1, 32'h0, 32'h6, 1'b0, 32'h0);
    run_scn(0, 1, 32'h0, 32'h100, 1'b0, 32'h0);
    run_scn(1, 0, 32'h8, 32'h0, 1'b0, 32'h0);

    // Reset landing in the middle of a read must abandon it.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    repeat (2) @(negedge clk);
    check("wait_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_wait_busy", {31'h0, busy}, 32'h0);
    check("rst_wait_cnt", {if_grants, d_grants}, 32'h0);
    m_if_cnt = 0; m_d_cnt = 0; m_last_d = 1'b1;
    m_if_rd = 32'h0; m_d_rd = 32'h0; m_if_err = 1'b0; m_d_err = 1'b0;
    any_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_ack = any_ack | if_ack | d_ack;
    end
    check("rst_wait_noack", {31'h0, any_ack}, 32'h0);

    force dut.if_grants_q = 16'hFFFF;
    @(negedge clk);
    release dut.if_grants_q;
    m_if_cnt = 65535;
    run_scn(1, 0, 32'h4, 32'h0, 1'b0, 32'h0);
    run_scn(1, 0, 32'h7, 32'h0, 1'b0, 32'h0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_scn(kind != 1, kind != 0, gen_addr(), gen_addr(), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the pipelined CPU's instruction-fetch port and its data port.
- This replaces the separate imem/dmem arrays with a unified memory.
- Requesters use a req/ack handshake. Requesters hold their request while waiting; the CPU wrapper converts a pending, un-acked request into a stall.
- Arbitration is round-robin. The block also keeps per-port grant counters and reports misaligned or out-of-range errors.

Parameters:
- ADDR_W, 6, RAM word-address width; depth = 2**ADDR_W words.
- RD_LAT, 1, RAM read latency in cycles, from the mem_en cycle to mem_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  32  fetch byte address; stable while if_req=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetch read data; valid when if_ack=1.
- if_err  out  1  fetch error; valid when if_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req=1.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  data read data; valid when d_ack=1.
- d_err  out  1  data error; valid when d_ack=1.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.
- busy  out  1  1 whenever state != IDLE.
- if_grants  out  16  count of completed fetch transactions; saturates at 0xFFFF.
- d_grants  out  16  count of completed data transactions; saturates at 0xFFFF.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge):
  - state=IDLE; all outputs 0; last_grant=DATA; counters 0.
  - An in-flight transaction is abandoned with no ack. A RAM write already strobed stands.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration:
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant (reset value DATA, so the first tie goes to fetch).
  - Latch the granted port, address, we and wdata, and update last_grant.
- IDLE, address check on the granted request:
  - Error if addr[1:0] != 0, or if addr[31:ADDR_W+2] != 0.
  - On error: go to DONE with err=1, no mem_en, rdata=0.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_addr = addr[ADDR_W+1:2]; mem_we = we (always 0 for fetch); mem_wdata = wdata.
  - Write goes to DONE next. Read goes to WAIT.
- WAIT (RD_LAT cycles):
  - A down-counter is loaded with RD_LAT-1.
  - When it reaches 0, capture mem_rdata and go to DONE.
  - mem_en=0 throughout WAIT.
- DONE (1 cycle):
  - The granted port's ack=1 and err valid; rdata holds the captured value (0 for writes and errors). The other port's ack stays 0.
  - The granted port's counter increments, saturating at 0xFFFF; error completions count too.
  - Next state is IDLE.
- Latency, with the request sampled in IDLE at cycle N:
  - Read: ack at N+2+RD_LAT.
  - Write: ack at N+2.
  - Error: ack at N+1.
  - Back-to-back throughput: one transaction per 3+RD_LAT cycles for reads, 3 cycles for writes.
- Handshake rules:
  - A requester holds req, addr, we and wdata stable until its ack cycle.
  - To end, it drops req on the edge closing the ack cycle. A req still high in the following IDLE cycle is a new request.
  - req sampled in ISSUE, WAIT or DONE is ignored; the losing requester simply waits.
- Between ack pulses, rdata and err hold their last values.
- Starvation bound: with both ports continuously requesting, they alternate strictly. Neither waits more than one full other-port transaction.
- Fetch with d_we=1 asserted is irrelevant; the fetch port is read-only by construction.

Test Plan:
- Reset, then d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF: mem_en=mem_we=1 with mem_addr=4 at N+1; d_ack at N+2; d_grants=1.
- RD_LAT=1, RAM word 4 = 0xDEADBEEF, if_req=1, if_addr=0x10: mem_en at N+1; if_ack at N+3 with if_rdata=0xDEADBEEF, if_err=0.
- if_req and d_req both held high from reset (read at 0x0 and 0x4), 4 transactions: grant order IF, D, IF, D; if_grants=2, d_grants=2.
- d_addr=0x6 (misaligned): d_ack at N+1 with d_err=1, d_rdata=0, mem_en never asserted. Repeat with d_addr=0x100 (ADDR_W=6): d_err=1.
- RD_LAT=3, read at 0x8: if_ack exactly 5 cycles after the request is sampled. Deassert reset mid-WAIT: no ack, busy=0 next cycle, counters=0.
- Force if_grants to 0xFFFF, complete one more fetch: count stays 0xFFFF.
